// File: rtl/timer_pwm_multi.sv
// Multi-channel timer / PWM block.
// One counter, advanced by a prescaled tick taken either from clk or from a
// synchronised external event, feeds CHANNELS compare-interrupt flags and PWM
// outputs. Period and compare values are double-buffered (shadow -> active)
// so reprogramming only takes effect at a wrap or on entry into a run.
module timer_pwm_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                i_mode,
    input  logic                      i_src_ext,
    input  logic                      i_event,
    input  logic [PRESC_W-1:0]        i_prescale,
    input  logic [WIDTH-1:0]          i_period,
    input  logic [CHANNELS*WIDTH-1:0] i_cmp,
    input  logic                      i_load,
    input  logic                      i_start,
    input  logic [CHANNELS-1:0]       i_irq_clr,
    output logic [WIDTH-1:0]          o_count,
    output logic                      o_overflow,
    output logic [CHANNELS-1:0]       o_cmp_irq,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      o_busy
);

    localparam logic [1:0] MODE_STOP    = 2'b00;
    localparam logic [1:0] MODE_CMP     = 2'b01;
    localparam logic [1:0] MODE_PWM     = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } os_state_e;

    // Registers
    logic                      sync1_r;
    logic                      sync2_r;
    logic                      sync3_r;
    logic [1:0]                mode_q_r;
    os_state_e                 state_r;
    logic [PRESC_W-1:0]        presc_cnt_r;
    logic [WIDTH-1:0]          count_r;
    logic [WIDTH-1:0]          per_sh_r;
    logic [CHANNELS*WIDTH-1:0] cmp_sh_r;
    logic [WIDTH-1:0]          per_act_r;
    logic [CHANNELS*WIDTH-1:0] cmp_act_r;
    logic                      overflow_r;
    logic [CHANNELS-1:0]       cmp_irq_r;
    logic [CHANNELS-1:0]       pwm_r;
    logic                      busy_r;

    // Combinational signals
    os_state_e                 state_nxt_s;
    logic                      ev_pulse_s;
    logic                      mode_chg_s;
    logic                      src_pulse_s;
    logic                      free_run_s;
    logic                      run_en_s;
    logic                      tick_s;
    logic                      wrap_s;
    logic                      start_s;
    logic                      upd_s;
    logic                      flag_mode_s;
    logic                      busy_nxt_s;
    logic [CHANNELS-1:0]       irq_set_s;
    logic [CHANNELS-1:0]       pwm_nxt_s;

    // Two-flop synchroniser plus the register used for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= i_event;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Tick generation, wrap detection and the update-event decision
    always_comb begin
        ev_pulse_s  = sync2_r & ~sync3_r;
        mode_chg_s  = (i_mode != mode_q_r);
        src_pulse_s = i_src_ext ? ev_pulse_s : 1'b1;
        free_run_s  = (i_mode == MODE_CMP) || (i_mode == MODE_PWM);
        // A mode change restarts everything, so nothing counts in that clk
        run_en_s    = ~mode_chg_s &
                      (free_run_s || ((i_mode == MODE_ONESHOT) && (state_r == ST_RUN)));
        tick_s      = run_en_s & src_pulse_s & (presc_cnt_r == i_prescale);
        wrap_s      = tick_s & (count_r == per_act_r);
        start_s     = ~mode_chg_s & (i_mode == MODE_ONESHOT) & (state_r == ST_IDLE) & i_start;
        upd_s       = wrap_s | start_s | (mode_chg_s & (mode_q_r == MODE_STOP));
        flag_mode_s = (i_mode == MODE_CMP) || (i_mode == MODE_ONESHOT);
    end

    // Per-channel compare-flag set conditions and next PWM levels
    always_comb begin
        irq_set_s = {CHANNELS{1'b0}};
        pwm_nxt_s = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            irq_set_s[k] = tick_s & flag_mode_s &
                           (count_r == cmp_act_r[k*WIDTH +: WIDTH]);
            pwm_nxt_s[k] = (i_mode == MODE_PWM) &
                           (count_r < cmp_act_r[k*WIDTH +: WIDTH]);
        end
    end

    // One-shot FSM next state and the busy level that follows from it
    always_comb begin
        state_nxt_s = state_r;
        if (mode_chg_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (wrap_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
        busy_nxt_s = free_run_s || ((i_mode == MODE_ONESHOT) && (state_nxt_s == ST_RUN));
    end

    // One-shot FSM state register and last-seen mode for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mode_q_r <= MODE_STOP;
        end else begin
            state_r  <= state_nxt_s;
            mode_q_r <= i_mode;
        end
    end

    // Prescaler and main counter; both sit at zero whenever not running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            count_r     <= {WIDTH{1'b0}};
        end else if (!run_en_s) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            count_r     <= {WIDTH{1'b0}};
        end else begin
            if (src_pulse_s) begin
                presc_cnt_r <= (presc_cnt_r == i_prescale) ? {PRESC_W{1'b0}}
                                                           : presc_cnt_r + PRESC_W'(1);
            end
            if (tick_s) begin
                count_r <= wrap_s ? {WIDTH{1'b0}} : count_r + WIDTH'(1);
            end
        end
    end

    // Shadow capture on load; active copy on update, bypassing the shadow on a coincident load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh_r  <= {WIDTH{1'b1}};
            cmp_sh_r  <= {(CHANNELS*WIDTH){1'b0}};
            per_act_r <= {WIDTH{1'b1}};
            cmp_act_r <= {(CHANNELS*WIDTH){1'b0}};
        end else begin
            if (i_load) begin
                per_sh_r <= i_period;
                cmp_sh_r <= i_cmp;
            end
            if (upd_s) begin
                if (i_load) begin
                    per_act_r <= i_period;
                    cmp_act_r <= i_cmp;
                end else begin
                    per_act_r <= per_sh_r;
                    cmp_act_r <= cmp_sh_r;
                end
            end
        end
    end

    // Registered outputs; a flag set beats a clear in the same clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            cmp_irq_r  <= {CHANNELS{1'b0}};
            pwm_r      <= {CHANNELS{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            overflow_r <= wrap_s;
            cmp_irq_r  <= irq_set_s | (cmp_irq_r & ~i_irq_clr);
            pwm_r      <= pwm_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign o_count    = count_r;
    assign o_overflow = overflow_r;
    assign o_cmp_irq  = cmp_irq_r;
    assign o_pwm      = pwm_r;
    assign o_busy     = busy_r;

endmodule

// File: doc/timer_pwm_multi.md
# timer_pwm_multi

Parametrised multi-channel timer/PWM block, the next-generation timer of the board-level timer subsystem. A single free-running or one-shot counter runs at a programmable rate derived from `clk` or from an external event input. It drives CHANNELS independent compare-interrupt flags and PWM outputs. Period and compare values are double-buffered, so reprogramming never produces glitched cycles. All logic is single-clock with clock enables, and no derived clocks are used.

## Interface
- WIDTH, 16, counter/period/compare width
- CHANNELS, 4, number of compare/PWM channels
- PRESC_W, 16, prescaler width
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- i_mode  in  2  00 stop, 01 compare, 10 PWM, 11 one-shot
- i_src_ext  in  1  1 = tick source is the external event, 0 = clk
- i_event  in  1  asynchronous external event input
- i_prescale  in  PRESC_W  divide ratio; ticks every i_prescale+1 source pulses
- i_period  in  WIDTH  counter top value (shadow input)
- i_cmp  in  CHANNELS*WIDTH  compare values; channel k uses bits [k*WIDTH +: WIDTH] (shadow input)
- i_load  in  1  strobe; captures i_period/i_cmp into the shadow registers
- i_start  in  1  strobe; starts a one-shot run
- i_irq_clr  in  CHANNELS  per-channel flag clear
- o_count  out  WIDTH  current counter value
- o_overflow  out  1  one-clk pulse at each wrap
- o_cmp_irq  out  CHANNELS  sticky compare flags
- o_pwm  out  CHANNELS  registered PWM outputs
- o_busy  out  1  counter is running

## Operation
- **Event synchroniser.** i_event passes through 2 flops, then a rising-edge detect register.
  - ev_pulse is one clk wide.
- **Source pulse.** Equals ev_pulse when i_src_ext=1; otherwise every clk.
- **Prescaler.** Counter p advances on each source pulse.
  - When p==i_prescale and a source pulse occurs: tick=1 and p<=0.
  - i_prescale=0 gives a tick on every source pulse.
- **Shadow and active registers.**
  - i_load copies inputs into the shadow registers.
  - Shadow copies into the active registers at an update event: the wrap, or entry from stop/IDLE.
  - If i_load and the update event coincide, the active registers take the i_load values directly.
- **Counter.** On tick:
  - if count==per_act: count<=0, o_overflow=1 for that clk, update event;
  - else count<=count+1.
  - per_act=0: count stays 0 and overflow pulses every tick.
- **Modes.**
  - stop: count and p held at 0, tick suppressed, o_busy=0, o_pwm=0.
  - compare: free-running counter.
    - On tick with count==cmp_act[k] (value before increment), set o_cmp_irq[k].
    - cmp_act[k]>per_act never fires.
  - PWM: o_pwm[k] <= (count < cmp_act[k]).
    - cmp=0 gives constant low.
    - cmp>per_act gives constant high.
  - one-shot: FSM with states IDLE and RUN.
    - IDLE→RUN on i_start (update event at entry).
    - RUN→IDLE at the wrap; the overflow pulse is still issued.
    - i_start while in RUN is ignored.
    - Compare flags operate as in compare mode.
- **Any change of i_mode.** count<=0, p<=0, FSM<=IDLE. Flags and shadow registers are kept.
- **Interrupt flags.** Set and i_irq_clr in the same clk for the same channel: set wins.
- **o_busy.** 1 in compare or PWM mode, or in RUN state.

## Timing
- Reset values:
  - count=0, p=0, FSM=IDLE;
  - o_overflow=0, o_cmp_irq=0, o_pwm=0, o_busy=0;
  - per_act=all ones, cmp_act=0, shadow=per all ones / cmp 0;
  - sync flops=0.
- rst_n asserted mid-run returns all state to reset values immediately.
- The count register updates on the clk after a tick.
- o_cmp_irq is set on the clk edge where the matching tick is sampled.
- o_pwm lags count by 1 clk (registered compare).
- External source: a rising edge at i_event produces its tick 3 clk later. Edges must be ≥2 clk apart high and low.
- Each period is exactly (per_act+1)*(i_prescale+1) source pulses.
- The new period/compare takes effect on the first count after the wrap.

## Test plan
- **Compare.** WIDTH=8, CHANNELS=2, prescale 0, period 9, cmp0=3, mode 01 → count cycles 0..9, o_overflow pulses every 10 clk, irq0 sets when count 3 is sampled. irq0 stays set until i_irq_clr[0]. Clear and set in the same clk leaves it 1.
- **PWM.** Period 9, cmp0=4, cmp1=0, mode 10 → pwm0 high 4 of 10 clk (1-clk lag from count), pwm1 always 0. Then cmp1=10 → pwm1 always 1.
- **Double buffering.** PWM mode, load cmp0=7 while count=5 → duty stays 4 until the wrap, then becomes 7/10. A load coinciding with the wrap applies immediately.
- **Prescaler.** Prescale 2, period 3 → count increments every 3 clk, overflow every 12 clk. Mode change mid-count resets count and p to 0.
- **External source.** i_src_ext=1, prescale 1, 6 clean i_event pulses → count 3. Each tick occurs 3 clk after the second edge of its pair.
- **One-shot.** Mode 11, period 4, i_start → o_busy 1, count 0..4, a single overflow, then IDLE with count 0. A second i_start re-runs. rst_n low at count 2 → all outputs 0 at once.
